// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Optional macro FREQ_METER_SAT_EN: edge counter saturates instead of wrapping.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             edge_pulse;
  logic [31:0]      gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf_win;
  logic             last_gate;
  logic             cnt_wraps;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef FREQ_METER_SAT_EN
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  assign edge_pulse = s2 & ~s3;
  assign last_gate  = (state == GATE) && (gate_cnt == GATE_LAST);
  assign cnt_wraps  = edge_pulse && (edge_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // en is only looked at outside the gate window, so a window always completes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = GATE;
      GATE:    if (last_gate) state_nxt = DONE;
      DONE:    state_nxt = en ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The final GATE cycle's edge is folded into the result captured on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_win  <= 1'b0;
      freq_out <= '0;
      ovf      <= 1'b0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + 32'd1;
      if (edge_pulse) edge_cnt <= cnt_inc(edge_cnt);
      if (cnt_wraps)  ovf_win  <= 1'b1;
      if (last_gate) begin
        freq_out <= edge_pulse ? cnt_inc(edge_cnt) : edge_cnt;
        ovf      <= ovf_win | cnt_wraps;
      end
    end else begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_win  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (10-cycle/32-bit and 40-cycle/4-bit) against a window-sum model.
module tb_freq_meter;

  localparam int unsigned G0 = 10;
  localparam int unsigned G1 = 40;
  localparam int          W0 = 32;
  localparam int          W1 = 4;
  localparam int          NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          sig_in = 1'b0;
  logic [W0-1:0] freq0;
  logic          valid0, ovf0;
  logic [W1-1:0] freq1;
  logic          valid1, ovf1;

  int n_checks = 0;
  int n_errors = 0;

  bit     hist [0:NCYC+3];
  int     win_end [2];
  bit     exp_valid [2];
  bit     exp_ovf [2];
  longint exp_freq [2];
  int     gates [2] = '{G0, G1};
  int     widths [2] = '{W0, W1};

  freq_meter #(.GATE_CYCLES(G0), .CNT_W(W0)) u0 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq0), .valid(valid0), .ovf(ovf0));

  freq_meter #(.GATE_CYCLES(G1), .CNT_W(W1)) u1 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .freq_out(freq1), .valid(valid1), .ovf(ovf1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // A rising edge is seen by the counter 3 clocks after sig_in is first sampled high
  function automatic bit pulse(input int t);
    if (t < 3) return 1'b0;
    return hist[t-2] & ~hist[t-3];
  endfunction

  function automatic longint window_edges(input int last, input int g);
    longint n = 0;
    for (int t = last - g + 1; t <= last; t++) n += longint'(pulse(t));
    return n;
  endfunction

  task automatic model_step(input int i, input int c);
    longint total, maxv;
    exp_valid[i] = 1'b0;
    if (c == win_end[i]) begin
      total = window_edges(c, gates[i]);
      maxv  = (longint'(1) << widths[i]) - 1;
      exp_ovf[i] = (total > maxv);
`ifdef FREQ_METER_SAT_EN
      exp_freq[i] = (total > maxv) ? maxv : total;
`else
      exp_freq[i] = total & maxv;
`endif
      exp_valid[i] = 1'b1;
    end
    if (c > win_end[i] && en) win_end[i] = c + gates[i];
  endtask

  int dens = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      win_end[i] = -100;
      exp_valid[i] = 1'b0;
      exp_ovf[i] = 1'b0;
      exp_freq[i] = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      check("valid0", {63'd0, valid0}, {63'd0, exp_valid[0]});
      check("freq0", {32'd0, freq0}, exp_freq[0]);
      check("ovf0", {63'd0, ovf0}, {63'd0, exp_ovf[0]});
      check("valid1", {63'd0, valid1}, {63'd0, exp_valid[1]});
      check("freq1", {60'd0, freq1}, exp_freq[1]);
      check("ovf1", {63'd0, ovf1}, {63'd0, exp_ovf[1]});
      // Continuous period-2 input: fixed results for both gate lengths
      if (c > 3 && c < 260) begin
        if (valid0 === 1'b1) check("p2_freq0", {32'd0, freq0}, 64'd5);
        if (valid1 === 1'b1) begin
          check("p2_ovf1", {63'd0, ovf1}, 64'd1);
`ifdef FREQ_METER_SAT_EN
          check("p2_freq1", {60'd0, freq1}, 64'd15);
`else
          check("p2_freq1", {60'd0, freq1}, 64'd4);
`endif
        end
      end

      if (c < 3) begin
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
      end else if (c < 260) begin
        rst = 1'b0; en = 1'b1; sig_in = c[0];
      end else if (c < 400) begin
        sig_in = 1'b0;
      end else if (c < 520) begin
        sig_in = 1'b1;
      end else if (c < 600) begin
        en = 1'b0;
        sig_in = 1'($urandom_range(0, 1));
      end else begin
        if (c % 200 == 0) dens = int'($urandom_range(0, 3));
        rst = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 59) == 0) en = ~en;
        if (dens == 3 || int'($urandom_range(0, 3)) < dens) sig_in = ~sig_in;
      end

      hist[c] = sig_in;
      if (rst) begin
        hist[c] = 1'b0;
        if (c >= 1) hist[c-1] = 1'b0;
        if (c >= 2) hist[c-2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          win_end[i] = -100;
          exp_valid[i] = 1'b0;
          exp_ovf[i] = 1'b0;
          exp_freq[i] = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) model_step(i, c);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50_000_000, gate window length in clk cycles (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter CNT_W, default 32, width of edge counter and result.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port en  input  1  measurement enable; level-sensitive.
REQ-006 SHALL have port sig_in  input  1  signal under measurement; asynchronous to clk.
REQ-007 SHALL have port freq_out  output  CNT_W  rising-edge count of the last completed window.
REQ-008 SHALL have port valid  output  1  one-cycle pulse: freq_out updated this cycle.
REQ-009 SHALL have port ovf  output  1  last completed window's edge count exceeded 2^CNT_W-1.

Function
REQ-010 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) plus a delay flop s3; edge_pulse = s2 & ~s3, combinational, 3 clk after the sig_in rise.
REQ-011 SHALL implement FSM states IDLE, GATE, DONE.
REQ-012 IDLE: gate_cnt = 0, edge_cnt = 0; go to GATE on the next edge when en = 1.
REQ-013 GATE: gate_cnt increments each cycle; edge_cnt increments in every cycle where edge_pulse = 1, including the cycle where gate_cnt = GATE_CYCLES-1.
REQ-014 SHALL leave GATE for DONE after exactly GATE_CYCLES cycles in GATE (gate_cnt = GATE_CYCLES-1).
REQ-015 DONE lasts exactly one cycle: freq_out holds the final edge_cnt, ovf holds the window overflow flag, valid = 1.
REQ-016 Leaving DONE: go to GATE with gate_cnt = 0, edge_cnt = 0 if en = 1, else go to IDLE.
REQ-017 SHALL NOT count edges whose edge_pulse falls in DONE or IDLE (one dead cycle per back-to-back window).
REQ-018 SHALL keep freq_out and ovf stable between DONE cycles.
REQ-019 en deasserted during GATE: the window SHALL complete normally; en is sampled only in IDLE and DONE.
REQ-020 Overflow: an increment at edge_cnt = 2^CNT_W-1 SHALL set the internal window overflow flag; the flag clears at window start.
REQ-021 gate_cnt SHALL be 32 bits wide, independent of CNT_W.

Reset
REQ-022 rst = 1 at a clk edge SHALL force: state = IDLE, gate_cnt = 0, edge_cnt = 0, s1/s2/s3 = 0, freq_out = 0, valid = 0, ovf = 0.
REQ-023 Reset mid-GATE SHALL discard the partial window; no valid pulse is produced for it.
REQ-024 rst SHALL take priority over en and every FSM transition.

Configuration
REQ-025 Macro FREQ_METER_SAT_EN defined: edge_cnt SHALL saturate at 2^CNT_W-1 on overflow.
REQ-026 Macro FREQ_METER_SAT_EN undefined: edge_cnt SHALL wrap modulo 2^CNT_W.
REQ-027 ovf behaviour SHALL be identical in both configurations.

Verification
REQ-028 GATE_CYCLES=10, CNT_W=32, en=1, sig_in period 2 clk -> first valid: freq_out=5, ovf=0; subsequent valid pulses every 11 clk, each with freq_out=5.
REQ-029 GATE_CYCLES=10, sig_in held 0 -> freq_out=0, valid pulses every 11 clk; sig_in held 1 -> freq_out=0.
REQ-030 GATE_CYCLES=40, CNT_W=4, sig_in period 2 -> ovf=1; freq_out=15 with FREQ_METER_SAT_EN, freq_out=4 without it.
REQ-031 GATE_CYCLES=10, rst pulsed at gate_cnt=5 with en=1 -> outputs all 0 the next cycle; no valid until 10 further GATE cycles complete; freq_out reflects only post-reset edges.
REQ-032 GATE_CYCLES=10, en dropped at gate_cnt=3 -> one valid with the full-window count, then IDLE with valid=0 and freq_out held.
REQ-033 Single sig_in pulse arriving 3 clk before the last GATE cycle -> counted (freq_out=1); same pulse arriving 2 clk before -> not counted (freq_out=0).
